seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed 7-segment display driver for the vending-machine front panel. It replaces the fixed 4-digit scanner with a configurable digit count, refresh rate and output polarities. It adds per-digit decimal points, leading-zero blanking, PWM brightness and a tear-free frame snapshot. It sits between the price/credit formatting logic and the board's seg/an/dp pins.

## Interface

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, legal range 1..8.
- DIV_BITS, 13: prescaler width. A digit slot lasts 2^DIV_BITS clk cycles. Minimum 4.
- SEG_ACTIVE_LOW, 1: 1 inverts seg and dp at the pins.
- AN_ACTIVE_LOW, 1: 1 inverts an at the pins.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- clr  in  1  asynchronous, active-high reset.
- digits  in  4*NUM_DIGITS  hex nibbles. Nibble i is digits[4i+3:4i]; digit 0 is the rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit; bit i belongs to digit i.
- blank_en  in  1  enables leading-zero suppression.
- bright  in  4  brightness: 0 gives 1/16 duty, 15 gives full duty.
- seg  out  7  segments {g,f,e,d,c,b,a}, driven at pin polarity.
- dp  out  1  decimal point, driven at pin polarity.
- an  out  NUM_DIGITS  digit enables, driven at pin polarity.
- frame_done  out  1  one-cycle pulse at each frame start.

## Operation

- Prescaler `pre` (DIV_BITS bits) increments every clk and wraps. `tick` is asserted when `pre` is all ones. `tick` is a clock enable; the design has no derived clocks.
- Index register `idx` (clog2(NUM_DIGITS) bits, minimum 1 bit) has reset value 0. On each tick:
  - If idx==0: idx ← NUM_DIGITS-1, shadow ← {digits, dp_in}, frame_done ← 1 for that cycle.
  - Otherwise: idx ← idx-1.
- The scan order is therefore leftmost to rightmost.
- Shadow registers hold the frame being displayed. Input changes mid-frame are ignored until the next wrap.
- On each tick, seg and dp load the pattern for the new idx. The source is the live inputs on a wrap tick and the shadow on any other tick.
- Decode uses the standard hex font, 0-9 and A-F, with all codes valid (e.g. 0 → 0111111, 8 → 1111111, F → 1110001 active-high).
- Blanking: with blank_en=1, digit i≥1 shows all segments off if its nibble and every more-significant nibble are 0. Digit 0 is never blanked. dp is shown even on a blanked digit.
- PWM: an[idx] is active when pre[DIV_BITS-1:DIV_BITS-4] ≤ bright. All other anodes are always inactive.
- Polarity inversion is applied at the final output registers only; internal logic is active-high.

## Timing

- Reset values, while clr is high and immediately on assertion:
  - seg = all segments off and dp = off, at pin polarity (0x7F / 1 when active-low).
  - an = all digits off.
  - frame_done = 0.
  - pre = 0, idx = 0, shadow = 0.
- All outputs are registered. No combinational path runs from any input to any output.
- First tick is at cycle 2^DIV_BITS-1 after reset release. It is a wrap: it loads the shadow, selects digit NUM_DIGITS-1 and pulses frame_done.
- seg, dp and idx change only on tick edges. an is re-registered every clk, so PWM edges are clk-accurate.
- In the first slot cycle after a tick, pre=0, so the new anode is on for every bright value. bright=15 means the anode is continuously on for the whole slot.
- Frame period = NUM_DIGITS × 2^DIV_BITS cycles. frame_done pulses are exactly one frame period apart.
- A bright change takes effect on the next clk. digits, dp_in and blank_en changes take effect at the next wrap.
- clr asserted mid-frame forces reset values at once. After release, the scan restarts from the first-tick rule.
- NUM_DIGITS=1: every tick is a wrap, and frame_done pulses every 2^DIV_BITS cycles.

## Structure

- Package seg7_pkg holds:
  - the 16-entry active-high font constant;
  - SEG_OFF;
  - a function for the digit-index width.
- Sub-module seg7_hex_decode: combinational, 4-bit nibble plus blank input to a 7-bit active-high pattern. Instantiate it once on the muxed nibble, not once per digit.

## Test plan

All scenarios use DIV_BITS=4.

- Reset and first frame: NUM_DIGITS=4, digits=0x1234, polarities active-low, bright=15.
  - During reset: seg=0x7F, an=0xF.
  - First tick (cycle 15): an=0b0111, seg=~0000110 ("1"), frame_done=1 for one cycle.
  - Then an follows 1011/1101/1110 with "2","3","4", each for 16 cycles.
- Snapshot: change digits to 0xABCD at cycle 40, mid-frame.
  - The remaining digits of the current frame still show 3 and 4.
  - 'A' appears only after the next frame_done.
- Blanking: blank_en=1, digits=0x0050, dp_in=0b1000.
  - Digit 3 shows no segments but dp is on.
  - Digit 2 is blank with dp off; digits 1 and 0 show "5" and "0".
  - digits=0x0000 shows only the rightmost "0".
- PWM: bright=3.
  - Each anode is active for exactly 4 of 16 slot cycles, starting at the cycle after the tick.
  - bright=0 gives 1 cycle; bright=15 gives 16.
- Parametrisation: NUM_DIGITS=8 and NUM_DIGITS=1 with active-high polarities.
  - frame_done period is 128 and 16 cycles respectively.
  - Exactly one an bit is high during each digit's PWM-on window.
- Async reset mid-scan: assert clr for 3 cycles between ticks.
  - Outputs go off with no clk edge needed.
  - After release, the first tick arrives at cycle 15 and selects the leftmost digit.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: active-high hex font,
// blank pattern and the digit-index width helper.
package seg7_pkg;

  // Segment order {g,f,e,d,c,b,a}, active-high; entry 15 ('F') first.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic int unsigned idx_width(input int unsigned num_digits);
    return (num_digits <= 1) ? 1 : $clog2(num_digits);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-segment decoder with a blank override, active-high.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = blank_i ? SEG_OFF : HEX_FONT[nibble_i];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner: frame snapshot, leading-zero blanking,
// per-digit decimal points and PWM brightness on the anode enables.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned DIV_BITS       = 13,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_en,
  input  logic [3:0]              bright,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned          IdxW    = idx_width(NUM_DIGITS);
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [6:0]           SegPol  = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AnPol  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [DIV_BITS-1:0]     pre_q, pre_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shd_dig_q, shd_dig_d;
  logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic                    shd_blank_q, shd_blank_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;

  logic                    tick, wrap;
  logic [4*NUM_DIGITS-1:0] src_dig;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic                    src_blank;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    higher_nz;
  logic                    cur_blank;
  logic [6:0]              dec_seg;
  logic                    pwm_on;
  logic [NUM_DIGITS-1:0]   an_hi;

  assign tick = &pre_q;
  assign wrap = tick && (idx_q == '0);

  // On a wrap tick the live inputs are both the new shadow and the pattern source.
  always_comb begin
    src_dig   = wrap ? digits   : shd_dig_q;
    src_dp    = wrap ? dp_in    : shd_dp_q;
    src_blank = wrap ? blank_en : shd_blank_q;
  end

  always_comb begin
    pre_d = pre_q + DIV_BITS'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = wrap ? LastIdx : idx_q - IdxW'(1);
    end
  end

  // Select the nibble for the incoming digit and look for any non-zero digit at or above it.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    higher_nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IdxW'(i) == idx_d) begin
        cur_nib = src_dig[4*i +: 4];
        cur_dp  = src_dp[i];
      end
      if ((IdxW'(i) >= idx_d) && (src_dig[4*i +: 4] != 4'h0)) begin
        higher_nz = 1'b1;
      end
    end
    cur_blank = src_blank && (idx_d != '0) && !higher_nz;
  end

  seg7_hex_decode u_decode (
    .nibble_i (cur_nib),
    .blank_i  (cur_blank),
    .seg_o    (dec_seg)
  );

  // Anode is evaluated against next-cycle state so the slot's first cycle (pre=0) is lit.
  always_comb begin
    pwm_on = (pre_d[DIV_BITS-1 -: 4] <= bright);
    an_hi  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_hi[i] = (IdxW'(i) == idx_d) && pwm_on;
    end
  end

  always_comb begin
    shd_dig_d   = shd_dig_q;
    shd_dp_d    = shd_dp_q;
    shd_blank_d = shd_blank_q;
    if (wrap) begin
      shd_dig_d   = digits;
      shd_dp_d    = dp_in;
      shd_blank_d = blank_en;
    end
    seg_d = tick ? (dec_seg ^ SegPol) : seg_q;
    dp_d  = tick ? (cur_dp ^ SEG_ACTIVE_LOW) : dp_q;
    an_d  = an_hi ^ AnPol;
    fd_d  = wrap;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pre_q       <= '0;
      idx_q       <= '0;
      shd_dig_q   <= '0;
      shd_dp_q    <= '0;
      shd_blank_q <= 1'b0;
      seg_q       <= SEG_OFF ^ SegPol;
      dp_q        <= SEG_ACTIVE_LOW;
      an_q        <= AnPol;
      fd_q        <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      shd_dig_q   <= shd_dig_d;
      shd_dp_q    <= shd_dp_d;
      shd_blank_q <= shd_blank_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      fd_q        <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three instances (4/8/1 digits) checked every cycle
// against a cycle-count model, plus literal spot checks.
module tb_seg7_scan_driver;

  localparam int Div  = 4;
  localparam int Slot = 16;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] digits;
  logic [7:0]  dp_in;
  logic        blank_en;
  logic [3:0]  bright;

  logic [6:0] seg4, seg8, seg1;
  logic       dp4, dp8, dp1;
  logic [3:0] an4;
  logic [7:0] an8;
  logic [0:0] an1;
  logic       fd4, fd8, fd1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .DIV_BITS(Div), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
  u_dut4 (.clk(clk), .clr(clr), .digits(digits[15:0]), .dp_in(dp_in[3:0]), .blank_en(blank_en),
          .bright(bright), .seg(seg4), .dp(dp4), .an(an4), .frame_done(fd4));

  seg7_scan_driver #(.NUM_DIGITS(8), .DIV_BITS(Div), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0))
  u_dut8 (.clk(clk), .clr(clr), .digits(digits), .dp_in(dp_in), .blank_en(blank_en),
          .bright(bright), .seg(seg8), .dp(dp8), .an(an8), .frame_done(fd8));

  seg7_scan_driver #(.NUM_DIGITS(1), .DIV_BITS(Div), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0))
  u_dut1 (.clk(clk), .clr(clr), .digits(digits[3:0]), .dp_in(dp_in[0:0]), .blank_en(blank_en),
          .bright(bright), .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Model: everything derives from n = clock edges since reset release.
  int          nd [3] = '{4, 8, 1};
  int          n = 0;
  logic [31:0] fr_dig   [3] = '{default: '0};
  logic [7:0]  fr_dp    [3] = '{default: '0};
  logic        fr_blank [3] = '{default: 1'b0};
  logic [6:0]  e_seg    [3] = '{default: '0};
  logic        e_dp     [3] = '{default: 1'b0};
  logic [7:0]  e_an     [3] = '{default: '0};
  logic        e_fd     [3] = '{default: 1'b0};

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      n = 0;
      for (int u = 0; u < 3; u++) begin
        fr_dig[u] = '0; fr_dp[u] = '0; fr_blank[u] = 1'b0;
        e_seg[u] = '0; e_dp[u] = 1'b0; e_an[u] = '0; e_fd[u] = 1'b0;
      end
    end else begin
      int p, k, pos, dig;
      logic [31:0] dmask;
      logic [3:0]  nib;
      n = n + 1;
      p = n % Slot;
      k = n / Slot;
      for (int u = 0; u < 3; u++) begin
        dmask = (nd[u] >= 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * nd[u])) - 32'd1);
        pos = (k > 0) ? (k - 1) % nd[u] : -1;
        dig = (k > 0) ? nd[u] - 1 - pos : 0;
        e_fd[u] = 1'b0;
        if (p == 0 && k > 0) begin
          if (pos == 0) begin
            fr_dig[u]   = digits & dmask;
            fr_dp[u]    = dp_in & dmask[7:0];
            fr_blank[u] = blank_en;
            e_fd[u]     = 1'b1;
          end
          nib = 4'((fr_dig[u] >> (4 * dig)) & 32'hF);
          e_dp[u] = fr_dp[u][dig];
          if (fr_blank[u] && dig >= 1 && (fr_dig[u] >> (4 * dig)) == 32'd0) e_seg[u] = 7'h00;
          else e_seg[u] = font(nib);
        end
        e_an[u] = ((p >> (Div - 4)) <= int'(bright)) ? (8'd1 << dig) : 8'd0;
      end
    end
  end

  always @(negedge clk) begin
    check("seg4", 32'(seg4), 32'(e_seg[0] ^ 7'h7F));
    check("dp4",  32'(dp4),  32'(e_dp[0] ^ 1'b1));
    check("an4",  32'(an4),  32'(e_an[0][3:0] ^ 4'hF));
    check("fd4",  32'(fd4),  32'(e_fd[0]));
    check("seg8", 32'(seg8), 32'(e_seg[1]));
    check("dp8",  32'(dp8),  32'(e_dp[1]));
    check("an8",  32'(an8),  32'(e_an[1]));
    check("fd8",  32'(fd8),  32'(e_fd[1]));
    check("seg1", 32'(seg1), 32'(e_seg[2]));
    check("dp1",  32'(dp1),  32'(e_dp[2]));
    check("an1",  32'(an1),  32'(e_an[2][0]));
    check("fd1",  32'(fd1),  32'(e_fd[2]));
  end

  function automatic logic fd_of(input int u);
    return (u == 0) ? fd4 : (u == 1) ? fd8 : fd1;
  endfunction

  task automatic wait_fd(input int u, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!fd_of(u) && cyc < 400);
    check("wait_fd", 32'(fd_of(u)), 32'd1);
  endtask

  initial begin
    int c, on;
    clr = 1'b1; digits = 32'h0000_1234; dp_in = 8'h00; blank_en = 1'b0; bright = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_seg4", 32'(seg4), 32'h7F);
    check("rst_an4",  32'(an4),  32'hF);
    check("rst_dp4",  32'(dp4),  32'h1);
    check("rst_an8",  32'(an8),  32'h0);
    clr = 1'b0;

    // Reset and first frame
    wait_fd(0, c);
    check("first_tick_cycle", 32'(c), 32'd16);
    check("first_an4",  32'(an4),  32'b0111);
    check("first_seg4", 32'(seg4), 32'h79);

    // Snapshot: change at cycle 40, mid-frame
    repeat (24) @(negedge clk);
    digits = 32'h0000_ABCD;
    repeat (10) @(negedge clk);
    check("snap_seg_3", 32'(seg4), 32'h30);
    repeat (16) @(negedge clk);
    check("snap_seg_4", 32'(seg4), 32'h19);
    wait_fd(0, c);
    check("snap_gap",   32'(c), 32'd14);
    check("snap_seg_A", 32'(seg4), 32'h08);

    // Leading-zero blanking
    blank_en = 1'b1; digits = 32'h0000_0050; dp_in = 8'b0000_1000;
    wait_fd(0, c);
    check("blank_d3_seg", 32'(seg4), 32'h7F);
    check("blank_d3_dp",  32'(dp4),  32'h0);
    repeat (16) @(negedge clk);
    check("blank_d2_seg", 32'(seg4), 32'h7F);
    check("blank_d2_dp",  32'(dp4),  32'h1);
    repeat (16) @(negedge clk);
    check("blank_d1_seg", 32'(seg4), 32'h12);
    repeat (16) @(negedge clk);
    check("blank_d0_seg", 32'(seg4), 32'h40);
    digits = 32'h0; dp_in = 8'h0;
    wait_fd(0, c);
    repeat (32) @(negedge clk);
    check("zero_d1_seg", 32'(seg4), 32'h7F);
    repeat (16) @(negedge clk);
    check("zero_d0_seg", 32'(seg4), 32'h40);
    check("zero_d0_an",  32'(an4),  32'b1110);

    // PWM duty per slot
    for (int b = 0; b < 3; b++) begin
      bright = (b == 0) ? 4'd3 : (b == 1) ? 4'd0 : 4'd15;
      wait_fd(0, c);
      check("pwm_first_on", 32'(an4), 32'b0111);
      on = 0;
      for (int i = 0; i < 16; i++) begin
        if (i > 0) @(negedge clk);
        if (an4 != 4'hF) on++;
      end
      check("pwm_on_cycles", 32'(on), 32'(int'(bright) + 1));
    end

    // Frame periods of the 8- and 1-digit instances
    wait_fd(1, c);
    wait_fd(1, c);
    check("fd8_period", 32'(c), 32'd128);
    wait_fd(2, c);
    wait_fd(2, c);
    check("fd1_period", 32'(c), 32'd16);

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) begin
        digits   = $urandom >> $urandom_range(0, 31);
        dp_in    = 8'($urandom);
        blank_en = 1'($urandom);
      end
      if ($urandom_range(0, 7) == 0) bright = 4'($urandom_range(0, 15));
    end

    // Asynchronous reset between ticks
    bright = 4'hF;
    wait_fd(0, c);
    repeat (5) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    check("async_seg4", 32'(seg4), 32'h7F);
    check("async_an4",  32'(an4),  32'hF);
    check("async_dp4",  32'(dp4),  32'h1);
    check("async_seg8", 32'(seg8), 32'h00);
    check("async_an8",  32'(an8),  32'h00);
    repeat (3) @(negedge clk);
    clr = 1'b0;
    wait_fd(0, c);
    check("restart_cycle", 32'(c), 32'd16);
    check("restart_an4",   32'(an4), 32'b0111);
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
